// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision constants, rounding modes and divider states.
// Used by the divider and reusable by the multiplier rounding path.
package fp_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam int MANT_W  = FRAC_W + 1;   // mantissa with hidden bit
   localparam int Q_W     = FRAC_W + 3;   // hidden + frac + guard + round
   localparam int E_W     = EXP_W + 2;    // signed working exponent

   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
   localparam logic [30:0] FP_INF_MAG = 31'h7F800000;
   localparam logic [30:0] FP_MAX_MAG = 31'h7F7FFFFF;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } rnd_mode_e;

   typedef enum logic [2:0] {
      IDLE,
      SPECIAL,
      DIV,
      ROUND,
      DONE
   } fp_div_state_e;

   function automatic rnd_mode_e to_rnd_mode(input logic [2:0] m);
      return (m > 3'd4) ? RNE : rnd_mode_e'(m);
   endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// fp_div_seq_if: operand/result valid-ready bundle for fp_div_seq.
// Carries the dz flag when FP_DIV_DZ_FLAG_EN is defined.
interface fp_div_seq_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] fp_X;
   logic [31:0] fp_Y;
   logic [2:0]  r_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] fp_Z;
   logic        ovrf;
   logic        udrf;

`ifdef FP_DIV_DZ_FLAG_EN
   logic        dz;

   modport master (
      output in_valid, fp_X, fp_Y, r_mode, out_ready,
      input  in_ready, out_valid, fp_Z, ovrf, udrf, dz
   );
   modport slave (
      input  in_valid, fp_X, fp_Y, r_mode, out_ready,
      output in_ready, out_valid, fp_Z, ovrf, udrf, dz
   );
`else
   modport master (
      output in_valid, fp_X, fp_Y, r_mode, out_ready,
      input  in_ready, out_valid, fp_Z, ovrf, udrf
   );
   modport slave (
      input  in_valid, fp_X, fp_Y, r_mode, out_ready,
      output in_ready, out_valid, fp_Z, ovrf, udrf
   );
`endif

endinterface

// File: rtl/fp_div_round.sv
// fp_div_round: combinational round/pack of a normalised quotient in [1,2),
// producing the packed result plus overflow/underflow flags.
module fp_div_round
   import fp_pkg::*;
(
   input  logic                  i_sign,
   input  logic signed [E_W-1:0] i_e,
   input  logic [Q_W-1:0]        i_q,
   input  logic                  i_sticky,
   input  logic [2:0]            i_r_mode,
   output logic [31:0]           o_fp_z,
   output logic                  o_ovrf,
   output logic                  o_udrf
);

   rnd_mode_e             w_mode;
   logic                  w_l, w_g, w_r, w_inexact, w_incr;
   logic [MANT_W:0]       w_sum;
   logic [FRAC_W-1:0]     w_frac;
   logic signed [E_W-1:0] w_e_r;

   always_comb begin
      // NOTE: every output gets a value before any branch so no latch is inferred.
      w_incr    = 1'b0;
      w_mode    = to_rnd_mode(i_r_mode);
      w_l       = i_q[2];
      w_g       = i_q[1];
      w_r       = i_q[0];
      w_inexact = w_g | w_r | i_sticky;
      case (w_mode)
         RNE:     w_incr = w_g & (w_r | i_sticky | w_l);
         RTZ:     w_incr = 1'b0;
         RDN:     w_incr = i_sign & w_inexact;
         RUP:     w_incr = !i_sign & w_inexact;
         RMM:     w_incr = w_g;
         default: w_incr = w_g & (w_r | i_sticky | w_l);
      endcase

      // A carry out leaves exactly 2.0, so the shifted fraction is all zeros.
      w_sum  = {1'b0, i_q[Q_W-1:2]} + {{MANT_W{1'b0}}, w_incr};
      w_frac = w_sum[MANT_W] ? w_sum[MANT_W-1:1] : w_sum[FRAC_W-1:0];
      w_e_r  = i_e + $signed({{(E_W-1){1'b0}}, w_sum[MANT_W]});

      o_ovrf = (w_e_r >= $signed(E_W'(EXP_MAX)));
      o_udrf = !o_ovrf && (w_e_r <= $signed(E_W'(0)));
      o_fp_z = {i_sign, w_e_r[EXP_W-1:0], w_frac};

      if (o_ovrf) begin
         case (w_mode)
            RTZ:     o_fp_z = {i_sign, FP_MAX_MAG};
            RDN:     o_fp_z = i_sign ? {1'b1, FP_INF_MAG} : {1'b0, FP_MAX_MAG};
            RUP:     o_fp_z = i_sign ? {1'b1, FP_MAX_MAG} : {1'b0, FP_INF_MAG};
            default: o_fp_z = {i_sign, FP_INF_MAG};
         endcase
      end else if (o_udrf) begin
         o_fp_z = {i_sign, 31'd0};
      end
   end

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential single-precision divider, radix-2 restoring, one op in flight.
// Define FP_DIV_DZ_FLAG_EN to add the dz (divide-by-zero) flag on the interface.
module fp_div_seq
   import fp_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   fp_div_seq_if.slave bus
);

   fp_div_state_e         r_state, w_state_nxt;
   logic [2:0]            r_rmode;
   logic                  r_sign;
   logic signed [E_W-1:0] r_e;
   logic [MANT_W+1:0]     r_rem;
   logic [MANT_W-1:0]     r_my;
   logic [Q_W-1:0]        r_q;
   logic [4:0]            r_cnt;
   logic [31:0]           r_z;
   logic                  r_ovrf, r_udrf;

   logic [EXP_W-1:0]      w_ex, w_ey;
   logic [FRAC_W-1:0]     w_fx, w_fy;
   logic                  w_zx, w_zy, w_ix, w_iy, w_nx, w_ny;
   logic                  w_sign, w_special, w_shift;
   logic [31:0]           w_spec_z;
   logic [MANT_W-1:0]     w_mx, w_my;
   logic signed [E_W-1:0] w_e0;
   logic                  w_ge;
   logic [MANT_W+1:0]     w_rem_sub;
   logic                  w_sticky;
   logic [31:0]           w_rnd_z;
   logic                  w_rnd_ovrf, w_rnd_udrf;
`ifdef FP_DIV_DZ_FLAG_EN
   logic                  r_dz, w_dz;
`endif

   always_comb begin
      w_ex   = bus.fp_X[30:23];
      w_ey   = bus.fp_Y[30:23];
      w_fx   = bus.fp_X[22:0];
      w_fy   = bus.fp_Y[22:0];
      w_zx   = (w_ex == '0);
      w_zy   = (w_ey == '0);
      w_ix   = (w_ex == '1) && (w_fx == '0);
      w_iy   = (w_ey == '1) && (w_fy == '0);
      w_nx   = (w_ex == '1) && (w_fx != '0);
      w_ny   = (w_ey == '1) && (w_fy != '0);
      w_sign = bus.fp_X[31] ^ bus.fp_Y[31];

      w_special = 1'b1;
      w_spec_z  = '0;
`ifdef FP_DIV_DZ_FLAG_EN
      w_dz      = 1'b0;
`endif
      if (w_nx || w_ny || (w_zx && w_zy) || (w_ix && w_iy)) begin
         w_spec_z = FP_QNAN;
      end else if (w_ix || w_zy) begin
         w_spec_z = {w_sign, FP_INF_MAG};
`ifdef FP_DIV_DZ_FLAG_EN
         w_dz     = w_zy && !w_ix;
`endif
      end else if (w_zx || w_iy) begin
         w_spec_z = {w_sign, 31'd0};
      end else begin
         w_special = 1'b0;
      end

      // Pre-align so the first quotient bit is always the hidden 1.
      w_mx    = {1'b1, w_fx};
      w_my    = {1'b1, w_fy};
      w_shift = (w_mx < w_my);
      w_e0    = $signed({2'b00, w_ex}) - $signed({2'b00, w_ey})
                + $signed(E_W'(BIAS)) - $signed(E_W'(w_shift));

      w_ge      = (r_rem >= {2'b00, r_my});
      w_rem_sub = w_ge ? (r_rem - {2'b00, r_my}) : r_rem;
      w_sticky  = |r_rem;
   end

   fp_div_round u_round (
      .i_sign   (r_sign),
      .i_e      (r_e),
      .i_q      (r_q),
      .i_sticky (w_sticky),
      .i_r_mode (r_rmode),
      .o_fp_z   (w_rnd_z),
      .o_ovrf   (w_rnd_ovrf),
      .o_udrf   (w_rnd_udrf)
   );

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid) w_state_nxt = w_special ? SPECIAL : DIV;
         SPECIAL: w_state_nxt = DONE;
         DIV:     if (r_cnt == 5'(Q_W - 1)) w_state_nxt = ROUND;
         ROUND:   w_state_nxt = DONE;
         DONE:    if (bus.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rmode <= '0;
         r_sign  <= 1'b0;
         r_e     <= '0;
         r_rem   <= '0;
         r_my    <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_z     <= '0;
         r_ovrf  <= 1'b0;
         r_udrf  <= 1'b0;
`ifdef FP_DIV_DZ_FLAG_EN
         r_dz    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (bus.in_valid) begin
               r_rmode <= bus.r_mode;
               r_sign  <= w_sign;
               r_e     <= w_e0;
               r_rem   <= w_shift ? {1'b0, w_mx, 1'b0} : {2'b00, w_mx};
               r_my    <= w_my;
               r_q     <= '0;
               r_cnt   <= '0;
               r_ovrf  <= 1'b0;
               r_udrf  <= 1'b0;
               if (w_special) r_z <= w_spec_z;
`ifdef FP_DIV_DZ_FLAG_EN
               r_dz    <= w_dz;
`endif
            end
            DIV: begin
               r_rem <= {w_rem_sub[MANT_W:0], 1'b0};
               r_q   <= {r_q[Q_W-2:0], w_ge};
               r_cnt <= r_cnt + 5'd1;
            end
            ROUND: begin
               r_z    <= w_rnd_z;
               r_ovrf <= w_rnd_ovrf;
               r_udrf <= w_rnd_udrf;
            end
`ifdef FP_DIV_DZ_FLAG_EN
            DONE: if (bus.out_ready) r_dz <= 1'b0;
`endif
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.fp_Z      = r_z;
   assign bus.ovrf      = r_ovrf;
   assign bus.udrf      = r_udrf;
`ifdef FP_DIV_DZ_FLAG_EN
   assign bus.dz        = r_dz;
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed vectors for fp_div_seq covering rounding modes, specials,
// overflow/underflow, output back-pressure and mid-operation reset.
module tb_fp_div_seq;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   fp_div_seq_if ifc ();

   fp_div_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  m;
      logic [31:0] z;
      logic        ov;
      logic        ud;
   } vec_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Launches one op and returns the cycle (accept cycle = 0) at which out_valid is seen.
   task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] m, output int lat);
      @(negedge clk);
      ifc.in_valid  = 1'b1;
      ifc.fp_X      = x;
      ifc.fp_Y      = y;
      ifc.r_mode    = m;
      ifc.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      lat = 1;
      while (!ifc.out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic finish_op();
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_tests++;
      if ({ifc.in_ready, ifc.out_valid, ifc.ovrf, ifc.udrf} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl {in_ready,out_valid,ovrf,udrf} got %b expected 1000",
                  {ifc.in_ready, ifc.out_valid, ifc.ovrf, ifc.udrf});
      end
      n_tests++;
      if (ifc.fp_Z !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_fp_Z got %08h expected 00000000", ifc.fp_Z);
      end
`ifdef FP_DIV_DZ_FLAG_EN
      n_tests++;
      if (ifc.dz !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dz got %b expected 0", ifc.dz);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      vec_t v [8];
      int   lat;
      v[0] = '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0};
      v[1] = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 1'b0, 1'b0};
      v[2] = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 1'b0, 1'b0};
      v[3] = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 1'b0, 1'b0};
      v[4] = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 1'b0, 1'b0};
      v[5] = '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 1'b0, 1'b0};
      v[6] = '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 1'b0, 1'b0};
      v[7] = '{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         start_op(v[i].x, v[i].y, v[i].m, lat);
         n_tests++;
         if (ifc.fp_Z !== v[i].z) begin
            n_fail++;
            $display("FAIL normal[%0d] fp_Z got %08h expected %08h", i, ifc.fp_Z, v[i].z);
         end
         n_tests++;
         if ({ifc.ovrf, ifc.udrf} !== {v[i].ov, v[i].ud}) begin
            n_fail++;
            $display("FAIL normal[%0d] flags got %b expected %b", i,
                     {ifc.ovrf, ifc.udrf}, {v[i].ov, v[i].ud});
         end
         n_tests++;
         if (lat !== 28) begin
            n_fail++;
            $display("FAIL normal[%0d] latency got %0d expected 28", i, lat);
         end
         finish_op();
      end
   endtask

   task automatic test_special();
      vec_t v [8];
      logic dz_exp [8];
      int   lat;
      v[0] = '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0};
      v[1] = '{32'h3F800000, 32'h80000000, 3'd0, 32'hFF800000, 1'b0, 1'b0};
      v[2] = '{32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 1'b0, 1'b0};
      v[3] = '{32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 1'b0, 1'b0};
      v[4] = '{32'h7FC00001, 32'h3F800000, 3'd1, 32'h7FC00000, 1'b0, 1'b0};
      v[5] = '{32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 1'b0, 1'b0};
      v[6] = '{32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 1'b0, 1'b0};
      v[7] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, 1'b0, 1'b0};
      dz_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         start_op(v[i].x, v[i].y, v[i].m, lat);
         n_tests++;
         if (ifc.fp_Z !== v[i].z) begin
            n_fail++;
            $display("FAIL special[%0d] fp_Z got %08h expected %08h", i, ifc.fp_Z, v[i].z);
         end
         n_tests++;
         if ({ifc.ovrf, ifc.udrf} !== 2'b00) begin
            n_fail++;
            $display("FAIL special[%0d] flags got %b expected 00", i, {ifc.ovrf, ifc.udrf});
         end
         n_tests++;
         if (lat !== 2) begin
            n_fail++;
            $display("FAIL special[%0d] latency got %0d expected 2", i, lat);
         end
`ifdef FP_DIV_DZ_FLAG_EN
         n_tests++;
         if (ifc.dz !== dz_exp[i]) begin
            n_fail++;
            $display("FAIL special[%0d] dz got %b expected %b", i, ifc.dz, dz_exp[i]);
         end
`else
         if (dz_exp[i] === 1'bx) $display("special[%0d] unexpected dz entry", i);
`endif
         finish_op();
      end
   endtask

   task automatic test_ovf_udf();
      vec_t v [8];
      int   lat;
      v[0] = '{32'h7F000000, 32'h00800000, 3'd0, 32'h7F800000, 1'b1, 1'b0};
      v[1] = '{32'h7F000000, 32'h00800000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0};
      v[2] = '{32'h7F000000, 32'h00800000, 3'd2, 32'h7F7FFFFF, 1'b1, 1'b0};
      v[3] = '{32'h7F000000, 32'h00800000, 3'd3, 32'h7F800000, 1'b1, 1'b0};
      v[4] = '{32'hFF000000, 32'h00800000, 3'd2, 32'hFF800000, 1'b1, 1'b0};
      v[5] = '{32'hFF000000, 32'h00800000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0};
      v[6] = '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 1'b0, 1'b1};
      v[7] = '{32'h80800000, 32'h40000000, 3'd0, 32'h80000000, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         start_op(v[i].x, v[i].y, v[i].m, lat);
         n_tests++;
         if (ifc.fp_Z !== v[i].z) begin
            n_fail++;
            $display("FAIL ovf_udf[%0d] fp_Z got %08h expected %08h", i, ifc.fp_Z, v[i].z);
         end
         n_tests++;
         if ({ifc.ovrf, ifc.udrf} !== {v[i].ov, v[i].ud}) begin
            n_fail++;
            $display("FAIL ovf_udf[%0d] flags got %b expected %b", i,
                     {ifc.ovrf, ifc.udrf}, {v[i].ov, v[i].ud});
         end
         n_tests++;
         if (lat !== 28) begin
            n_fail++;
            $display("FAIL ovf_udf[%0d] latency got %0d expected 28", i, lat);
         end
         finish_op();
      end
   endtask

   task automatic test_hold();
      int lat;
      start_op(32'h40C00000, 32'h40000000, 3'd0, lat);
      for (int i = 0; i < 5; i++) begin
         ifc.in_valid = 1'b1;
         ifc.fp_X     = 32'h3F800000;
         ifc.fp_Y     = 32'h3F800000;
         @(negedge clk);
         n_tests++;
         if (ifc.fp_Z !== 32'h40400000) begin
            n_fail++;
            $display("FAIL hold[%0d] fp_Z got %08h expected 40400000", i, ifc.fp_Z);
         end
         n_tests++;
         if ({ifc.out_valid, ifc.in_ready, ifc.ovrf, ifc.udrf} !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold[%0d] {out_valid,in_ready,ovrf,udrf} got %b expected 1000", i,
                     {ifc.out_valid, ifc.in_ready, ifc.ovrf, ifc.udrf});
         end
      end
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
      n_tests++;
      if ({ifc.in_ready, ifc.out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL hold_release {in_ready,out_valid} got %b expected 10",
                  {ifc.in_ready, ifc.out_valid});
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen_valid;
      @(negedge clk);
      ifc.in_valid  = 1'b1;
      ifc.fp_X      = 32'h3F800000;
      ifc.fp_Y      = 32'h40400000;
      ifc.r_mode    = 3'd0;
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({ifc.out_valid, ifc.fp_Z} !== {1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid out_valid/fp_Z got %b/%08h expected 0/00000000",
                  ifc.out_valid, ifc.fp_Z);
      end
      n_tests++;
      if (ifc.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid in_ready got %b expected 1", ifc.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ifc.out_valid === 1'b1) seen_valid++;
      end
      n_tests++;
      if (seen_valid !== 0 || ifc.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_after out_valid cycles got %0d in_ready %b expected 0 and 1",
                  seen_valid, ifc.in_ready);
      end
      start_op(32'h3F800000, 32'h3F800000, 3'd0, lat);
      n_tests++;
      if (ifc.fp_Z !== 32'h3F800000) begin
         n_fail++;
         $display("FAIL reset_mid_next fp_Z got %08h expected 3F800000", ifc.fp_Z);
      end
      n_tests++;
      if (lat !== 28) begin
         n_fail++;
         $display("FAIL reset_mid_next latency got %0d expected 28", lat);
      end
      finish_op();
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.fp_X      = '0;
      ifc.fp_Y      = '0;
      ifc.r_mode    = '0;
      ifc.out_ready = 1'b0;

      test_reset();
      test_normal();
      test_special();
      test_ovf_udf();
      test_hold();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
